// File: rtl/branch_resolution_unit_if.sv
// branch_resolution_unit_if: fetch-push, EX-resolve and BHT-update bundle of the branch resolution unit.
interface branch_resolution_unit_if #(
   parameter int PC_W  = 32,
   parameter int LOWER = 5,
   parameter int CNT_W = 16
);
   logic             push_valid;
   logic [PC_W-1:0]  push_pc;
   logic             push_pred_taken;
   logic [PC_W-1:0]  push_pred_target;
   logic             push_ready;
   logic             res_valid;
   logic             res_taken;
   logic             res_jump;
   logic [PC_W-1:0]  res_target;
   logic [PC_W-1:0]  res_pc_next;
   logic             flush;
   logic [PC_W-1:0]  redirect_pc;
   logic             upd_en;
   logic [LOWER-1:0] upd_addr;
   logic             upd_was_taken;
   logic             upd_jumped;
   logic [CNT_W-1:0] cnt_resolved;
   logic [CNT_W-1:0] cnt_mispredict;
   logic             res_error;
   modport master (
      output push_valid, push_pc, push_pred_taken, push_pred_target,
      output res_valid, res_taken, res_jump, res_target, res_pc_next,
      input  push_ready, flush, redirect_pc, upd_en, upd_addr, upd_was_taken, upd_jumped,
      input  cnt_resolved, cnt_mispredict, res_error
   );
   modport slave (
      input  push_valid, push_pc, push_pred_taken, push_pred_target,
      input  res_valid, res_taken, res_jump, res_target, res_pc_next,
      output push_ready, flush, redirect_pc, upd_en, upd_addr, upd_was_taken, upd_jumped,
      output cnt_resolved, cnt_mispredict, res_error
   );
endinterface

// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit: tracks in-flight predictions, resolves them against EX, flushes on mispredict
// and trains the 2-bit history table.
module branch_resolution_unit #(
   parameter int PC_W           = 32,
   parameter int LOWER          = 5,
   parameter int DEPTH          = 4,
   parameter int CNT_W          = 16,
   parameter int RECOVER_CYCLES = 2
) (
   input logic                  clk,
   input logic                  arst_n,
   branch_resolution_unit_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = $clog2(RECOVER_CYCLES + 2);
   typedef enum logic {RUN, RECOVER} state_t;
   state_t           r_state;
   logic [RW-1:0]    r_rec;
   logic [LOWER-1:0] r_idx [DEPTH];
   logic             r_pt  [DEPTH];
   logic [PC_W-1:0]  r_tg  [DEPTH];
   logic [AW-1:0]    r_wr, r_rd;
   logic [AW:0]      r_count;
   logic             r_flush, r_upd_en, r_upd_taken, r_upd_jump, r_err;
   logic [PC_W-1:0]  r_redirect;
   logic [LOWER-1:0] r_upd_addr;
   logic [CNT_W-1:0] r_cnt_res, r_cnt_mis;
   logic             w_push, w_pop, w_actual, w_mis;
   assign bus.push_ready = (r_state == RUN) && (r_count != (AW+1)'(DEPTH));
   assign w_push   = bus.push_valid && bus.push_ready;
   assign w_pop    = bus.res_valid && (r_count != '0);
   assign w_actual = bus.res_taken | bus.res_jump;
   assign w_mis    = w_pop && ((w_actual != r_pt[r_rd]) || (w_actual && bus.res_target != r_tg[r_rd]));
   // Only the history-table index of the PC is ever needed after the push.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_idx[r_wr] <= bus.push_pc[LOWER+1:2];
         r_pt[r_wr]  <= bus.push_pred_taken;
         r_tg[r_wr]  <= bus.push_pred_target;
      end
   end
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state     <= RUN;
         r_rec       <= '0;
         r_wr        <= '0;
         r_rd        <= '0;
         r_count     <= '0;
         r_flush     <= 1'b0;
         r_upd_en    <= 1'b0;
         r_upd_taken <= 1'b0;
         r_upd_jump  <= 1'b0;
         r_upd_addr  <= '0;
         r_redirect  <= '0;
         r_cnt_res   <= '0;
         r_cnt_mis   <= '0;
         r_err       <= 1'b0;
      end else begin
         r_upd_en <= w_pop;
         r_flush  <= w_mis;
         if (w_pop) begin
            r_upd_addr  <= r_idx[r_rd];
            r_upd_taken <= bus.res_taken;
            r_upd_jump  <= bus.res_jump;
            if (!(&r_cnt_res)) r_cnt_res <= r_cnt_res + CNT_W'(1);
         end
         if (bus.res_valid && r_count == '0) r_err <= 1'b1;
         if (w_mis) begin
            r_redirect <= w_actual ? bus.res_target : bus.res_pc_next;
            if (!(&r_cnt_mis)) r_cnt_mis <= r_cnt_mis + CNT_W'(1);
            // Everything younger than the mispredicted branch is on the wrong path.
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_state <= (RECOVER_CYCLES > 0) ? RECOVER : RUN;
            r_rec   <= RW'(RECOVER_CYCLES);
         end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (r_state == RECOVER) begin
               r_rec   <= r_rec - RW'(1);
               r_state <= (r_rec == RW'(1)) ? RUN : RECOVER;
            end
         end
      end
   end
   assign bus.flush          = r_flush;
   assign bus.redirect_pc    = r_redirect;
   assign bus.upd_en         = r_upd_en;
   assign bus.upd_addr       = r_upd_addr;
   assign bus.upd_was_taken  = r_upd_taken;
   assign bus.upd_jumped     = r_upd_jump;
   assign bus.cnt_resolved   = r_cnt_res;
   assign bus.cnt_mispredict = r_cnt_mis;
   assign bus.res_error      = r_err;
endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb_branch_resolution_unit: directed table, corner sequences and a queue-model random run
// for the branch resolution unit.
module tb_branch_resolution_unit;
   logic clk = 1'b0;
   logic arst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   branch_resolution_unit_if #(.PC_W(32), .LOWER(5), .CNT_W(16)) b();
   branch_resolution_unit_if #(.PC_W(32), .LOWER(5), .CNT_W(4))  s();
   branch_resolution_unit #(.PC_W(32), .LOWER(5), .DEPTH(4), .CNT_W(16), .RECOVER_CYCLES(2))
      u_dut (.clk(clk), .arst_n(arst_n), .bus(b));
   branch_resolution_unit #(.PC_W(32), .LOWER(5), .DEPTH(4), .CNT_W(4), .RECOVER_CYCLES(2))
      u_sat (.clk(clk), .arst_n(arst_n), .bus(s));
   typedef struct {
      logic [31:0] pc;  logic pt; logic [31:0] tg;
      logic rt; logic rj; logic [31:0] rtg; logic [31:0] rnx;
      logic ef; logic [31:0] er; logic [4:0] ea;
   } vec_t;
   typedef struct {logic [31:0] pc; logic pt; logic [31:0] tg;} ent_t;
   vec_t tv [8];
   ent_t q [$];
   ent_t h;
   int   blk, e_cr, e_cm;
   logic e_upd, e_flush, e_err, e_wt, e_j, exp_rdy, pv, rv, rt, rj, pt, act, mis, pop, push;
   logic [31:0] e_red, ppc, ptg, rtg, rnx;
   logic [4:0]  e_addr;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   task automatic idle_b;
      b.push_valid = 1'b0; b.push_pc = '0; b.push_pred_taken = 1'b0; b.push_pred_target = '0;
      b.res_valid = 1'b0; b.res_taken = 1'b0; b.res_jump = 1'b0; b.res_target = '0; b.res_pc_next = '0;
   endtask
   task automatic idle_s;
      s.push_valid = 1'b0; s.push_pc = '0; s.push_pred_taken = 1'b0; s.push_pred_target = '0;
      s.res_valid = 1'b0; s.res_taken = 1'b0; s.res_jump = 1'b0; s.res_target = '0; s.res_pc_next = '0;
   endtask
   task automatic drv_push(input logic v, input logic [31:0] pc, input logic p, input logic [31:0] tg);
      b.push_valid = v; b.push_pc = pc; b.push_pred_taken = p; b.push_pred_target = tg;
   endtask
   task automatic drv_res(input logic v, input logic t, input logic j, input logic [31:0] tg, input logic [31:0] nx);
      b.res_valid = v; b.res_taken = t; b.res_jump = j; b.res_target = tg; b.res_pc_next = nx;
   endtask
   task automatic chk_zero(input string n);
      chk({n, "_bits"}, 32'({b.flush, b.upd_en, b.upd_was_taken, b.upd_jumped, b.res_error, b.upd_addr}), 0);
      chk({n, "_redirect"}, b.redirect_pc, 0);
      chk({n, "_cnt_res"}, 32'(b.cnt_resolved), 0);
      chk({n, "_cnt_mis"}, 32'(b.cnt_mispredict), 0);
   endtask
   task automatic do_reset;
      idle_b;
      arst_n = 1'b0;
      step;
      step;
      chk_zero("reset");
      arst_n = 1'b1;
      step;
      chk("reset_ready", 32'(b.push_ready), 1);
   endtask
   initial begin
      idle_b;
      idle_s;
      do_reset;
      tv[0] = '{32'h40, 1'b1, 32'h80,  1'b1, 1'b0, 32'h80,  32'h44, 1'b0, 32'h0,   5'h10};
      tv[1] = '{32'h44, 1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 32'h48, 1'b1, 32'h100, 5'h11};
      tv[2] = '{32'h48, 1'b1, 32'h200, 1'b0, 1'b1, 32'h204, 32'h4C, 1'b1, 32'h204, 5'h12};
      tv[3] = '{32'h48, 1'b1, 32'h90,  1'b0, 1'b0, 32'h90,  32'h4C, 1'b1, 32'h4C,  5'h12};
      tv[4] = '{32'h50, 1'b0, 32'h0,   1'b0, 1'b0, 32'h123, 32'h54, 1'b0, 32'h4C,  5'h14};
      tv[5] = '{32'h7C, 1'b1, 32'h300, 1'b0, 1'b1, 32'h300, 32'h80, 1'b0, 32'h4C,  5'h1F};
      tv[6] = '{32'h84, 1'b1, 32'h88,  1'b1, 1'b1, 32'h88,  32'h88, 1'b0, 32'h4C,  5'h01};
      tv[7] = '{32'h90, 1'b0, 32'h0,   1'b0, 1'b1, 32'h500, 32'h94, 1'b1, 32'h500, 5'h04};
      for (int i = 0; i < 8; i++) begin
         chk("tbl_ready", 32'(b.push_ready), 1);
         drv_push(1'b1, tv[i].pc, tv[i].pt, tv[i].tg);
         step;
         idle_b;
         step;
         drv_res(1'b1, tv[i].rt, tv[i].rj, tv[i].rtg, tv[i].rnx);
         step;
         idle_b;
         chk("tbl_upd_en", 32'(b.upd_en), 1);
         chk("tbl_flush", 32'(b.flush), 32'(tv[i].ef));
         chk("tbl_redirect", b.redirect_pc, tv[i].er);
         chk("tbl_addr", 32'(b.upd_addr), 32'(tv[i].ea));
         chk("tbl_taken", 32'(b.upd_was_taken), 32'(tv[i].rt));
         chk("tbl_jumped", 32'(b.upd_jumped), 32'(tv[i].rj));
         step;
         chk("tbl_pulse", 32'({b.upd_en, b.flush}), 0);
         step;
         step;
      end
      chk("tbl_cnt_res", 32'(b.cnt_resolved), 8);
      chk("tbl_cnt_mis", 32'(b.cnt_mispredict), 4);
      chk("tbl_err", 32'(b.res_error), 0);
      // Direction mispredict with two younger entries, blocked recovery, then an empty resolve.
      drv_push(1'b1, 32'h44, 1'b0, 32'h0);  step;
      drv_push(1'b1, 32'h48, 1'b1, 32'h60); step;
      drv_push(1'b1, 32'h4C, 1'b0, 32'h0);  step;
      idle_b;
      drv_res(1'b1, 1'b1, 1'b0, 32'h100, 32'h48);
      step;
      idle_b;
      chk("dir_flush", 32'(b.flush), 1);
      chk("dir_redirect", b.redirect_pc, 32'h100);
      chk("dir_cnt_mis", 32'(b.cnt_mispredict), 5);
      chk("dir_ready0", 32'(b.push_ready), 0);
      drv_push(1'b1, 32'h1F0, 1'b0, 32'h0);
      step;
      chk("dir_flush_gone", 32'(b.flush), 0);
      chk("dir_ready1", 32'(b.push_ready), 0);
      step;
      chk("dir_ready2", 32'(b.push_ready), 1);
      idle_b;
      drv_res(1'b1, 1'b1, 1'b0, 32'h100, 32'h48);
      step;
      idle_b;
      chk("empty_upd", 32'({b.upd_en, b.flush}), 0);
      chk("empty_err", 32'(b.res_error), 1);
      chk("empty_cnt_res", 32'(b.cnt_resolved), 9);
      chk("empty_cnt_mis", 32'(b.cnt_mispredict), 5);
      step;
      chk("err_sticky", 32'(b.res_error), 1);
      // Fill, overflow attempts, pointer wrap, drain in order.
      do_reset;
      for (int k = 0; k < 4; k++) begin
         drv_push(1'b1, 32'h100 + 32'(k * 4), 1'b0, 32'h0);
         step;
      end
      chk("full_ready", 32'(b.push_ready), 0);
      drv_push(1'b1, 32'h1F0, 1'b0, 32'h0);
      step;
      chk("full_drop", 32'(b.push_ready), 0);
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) begin
            drv_push(1'b1, 32'h1F4, 1'b0, 32'h0);
            drv_res(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         end else begin
            drv_push(1'b1, 32'h110 + 32'((k / 2) * 4), 1'b0, 32'h0);
            drv_res(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         end
         step;
         chk("wrap_upd_en", 32'(b.upd_en), 32'(k % 2 == 0));
         if (k % 2 == 0) chk("wrap_addr", 32'(b.upd_addr), 32'(k / 2));
         chk("wrap_flush", 32'(b.flush), 0);
      end
      idle_b;
      for (int k = 3; k < 7; k++) begin
         drv_res(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         step;
         chk("drain_upd_en", 32'(b.upd_en), 1);
         chk("drain_addr", 32'(b.upd_addr), 32'(k));
      end
      step;
      chk("drain_empty_upd", 32'(b.upd_en), 0);
      chk("drain_err", 32'(b.res_error), 1);
      chk("drain_cnt_res", 32'(b.cnt_resolved), 7);
      chk("drain_cnt_mis", 32'(b.cnt_mispredict), 0);
      idle_b;
      // Random run against a queue model.
      do_reset;
      q.delete();
      blk = 0; e_cr = 0; e_cm = 0; e_err = 1'b0; e_red = '0;
      for (int c = 0; c < 1500; c++) begin
         pv  = 1'($urandom_range(0, 1));
         ppc = 32'($urandom_range(0, 255)) << 2;
         pt  = 1'($urandom_range(0, 1));
         ptg = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
         if (q.size() > 0) begin
            rv = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) begin
               rj  = q[0].pt & ($urandom_range(0, 2) == 0);
               rt  = q[0].pt & !rj;
               rtg = q[0].tg;
            end else begin
               rt  = 1'($urandom_range(0, 1));
               rj  = ($urandom_range(0, 3) == 0);
               rtg = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
            end
            rnx = q[0].pc + 32'd4;
         end else begin
            rv  = ($urandom_range(0, 15) == 0);
            rt  = 1'($urandom_range(0, 1));
            rj  = 1'b0;
            rtg = 32'h2000;
            rnx = 32'h3000;
         end
         drv_push(pv, ppc, pt, ptg);
         drv_res(rv, rt, rj, rtg, rnx);
         exp_rdy = (blk == 0) && (q.size() < 4);
         chk("rnd_ready", 32'(b.push_ready), 32'(exp_rdy));
         push = pv && exp_rdy;
         pop  = rv && (q.size() > 0);
         mis  = 1'b0;
         if (rv && q.size() == 0) e_err = 1'b1;
         e_upd   = pop;
         e_flush = 1'b0;
         if (pop) begin
            h      = q.pop_front();
            act    = rt | rj;
            mis    = (act != h.pt) || (act && rtg != h.tg);
            e_addr = h.pc[6:2];
            e_wt   = rt;
            e_j    = rj;
            e_cr   = (e_cr == 65535) ? e_cr : e_cr + 1;
            if (mis) begin
               e_cm    = (e_cm == 65535) ? e_cm : e_cm + 1;
               e_flush = 1'b1;
               e_red   = act ? rtg : rnx;
            end
         end
         if (push) q.push_back('{ppc, pt, ptg});
         if (mis) begin
            q.delete();
            blk = 2;
         end else if (blk > 0) blk--;
         step;
         chk("rnd_upd_en", 32'(b.upd_en), 32'(e_upd));
         chk("rnd_flush", 32'(b.flush), 32'(e_flush));
         chk("rnd_redirect", b.redirect_pc, e_red);
         if (e_upd) chk("rnd_upd", 32'({b.upd_addr, b.upd_was_taken, b.upd_jumped}), 32'({e_addr, e_wt, e_j}));
         chk("rnd_cnt_res", 32'(b.cnt_resolved), 32'(e_cr));
         chk("rnd_cnt_mis", 32'(b.cnt_mispredict), 32'(e_cm));
         chk("rnd_err", 32'(b.res_error), 32'(e_err));
      end
      idle_b;
      // Saturation on the 4-bit-counter instance.
      for (int i = 0; i < 20; i++) begin
         s.push_valid = 1'b1; s.push_pc = 32'h40; s.push_pred_taken = 1'b0;
         step;
         idle_s;
         s.res_valid = 1'b1; s.res_taken = 1'b1; s.res_target = 32'h80; s.res_pc_next = 32'h44;
         step;
         idle_s;
         chk("sat_flush", 32'(s.flush), 1);
         step;
         step;
      end
      chk("sat_cnt_mis", 32'(s.cnt_mispredict), 15);
      chk("sat_cnt_res", 32'(s.cnt_resolved), 15);
      // Reset asserted while a flush pulse is live.
      do_reset;
      drv_push(1'b1, 32'h44, 1'b0, 32'h0);
      step;
      idle_b;
      drv_res(1'b1, 1'b1, 1'b0, 32'h100, 32'h48);
      step;
      idle_b;
      chk("mid_flush", 32'(b.flush), 1);
      arst_n = 1'b0;
      #1;
      chk_zero("mid_reset");
      chk("mid_sat_cnt", 32'(s.cnt_mispredict), 0);
      step;
      arst_n = 1'b1;
      step;
      chk("mid_ready", 32'(b.push_ready), 1);
      chk_zero("mid_after");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
